// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset CPU: walks each instruction
// through fetch/decode/execute/memory/writeback and owns the unified memory port.
`timescale 1ns/1ps
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        reg_wr,
  output logic [1:0]  reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_ctrl,
  output logic [3:0]  state,
  output logic        retire,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JR       = 4'd11,
    S_JAL      = 4'd12,
    S_FAULT    = 4'd13
  } state_t;

  localparam logic [2:0]      ALU_ADD = 3'd0;
  localparam logic [2:0]      ALU_SUB = 3'd1;
  localparam logic [2:0]      ALU_SLT = 3'd3;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            pending_q, pending_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [1:0]      fcode_q, fcode_d;

  logic [5:0] op, funct;
  logic [2:0] r_ctrl;
  logic       fetch_req;
  logic       to_hit;
  logic       unused_instr;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign r_ctrl       = (funct == 6'b101010) ? ALU_SLT : ALU_ADD;
  assign fetch_req    = run | pending_q;
  assign to_hit       = (to_q == TO_LAST);
  assign unused_instr = ^instr[25:6];

  always_comb begin
    state_d      = state_q;
    pending_d    = 1'b0;
    to_d         = '0;
    fcode_d      = fcode_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_wr        = 1'b0;
    pc_wr        = 1'b0;
    pc_src       = 2'b00;
    reg_wr       = 1'b0;
    reg_dst      = 2'b00;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_ctrl     = ALU_ADD;
    retire       = 1'b0;
    fault        = 1'b0;
    fault_code   = 2'b00;
    state        = state_q;

    case (state_q)
      S_FETCH: begin
        mem_req   = fetch_req;
        alu_src_b = 2'b01;
        if (fetch_req) begin
          if (mem_ready) begin
            ir_wr   = 1'b1;
            pc_wr   = 1'b1;
            state_d = S_DECODE;
          end else if (to_hit) begin
            state_d = S_FAULT;
            fcode_d = 2'b10;
          end else begin
            pending_d = 1'b1;
            to_d      = to_q + 1'b1;
          end
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          6'b000000: begin
            if (funct == 6'b100000 || funct == 6'b100001 || funct == 6'b101010) begin
              state_d = S_EXEC_R;
            end else if (funct == 6'b001000) begin
              state_d = S_JR;
            end else begin
              state_d = S_FAULT;
              fcode_d = 2'b01;
            end
          end
          6'b001000, 6'b001001: state_d = S_EXEC_I;
          6'b100011, 6'b101011: state_d = S_MEM_ADDR;
          6'b000100, 6'b000101: state_d = S_BRANCH;
          6'b000011:            state_d = S_JAL;
          default: begin
            state_d = S_FAULT;
            fcode_d = 2'b01;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_ctrl  = r_ctrl;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_wr    = 1'b1;
        reg_dst   = 2'b01;
        retire    = 1'b1;
        alu_src_a = 1'b1;
        alu_ctrl  = r_ctrl;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_wr  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == 6'b100011) ? S_MEM_RD : S_MEM_WR;
      end
      // Data accesses share the fetch wait-state counter and fault path
      S_MEM_RD, S_MEM_WR: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (state_q == S_MEM_WR);
        if (mem_ready) begin
          retire  = (state_q == S_MEM_WR);
          state_d = (state_q == S_MEM_WR) ? S_FETCH : S_WB_MEM;
        end else if (to_hit) begin
          state_d = S_FAULT;
          fcode_d = 2'b10;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_WB_MEM: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        pc_wr     = op[0] ? ~zero : zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JR: begin
        pc_wr   = 1'b1;
        pc_src  = 2'b11;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        reg_wr  = 1'b1;
        reg_dst = 2'b10;
        pc_wr   = 1'b1;
        pc_src  = 2'b10;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: begin
        fault      = 1'b1;
        fault_code = fcode_q;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset must silence the memory port at once, even though FETCH requests on run
    if (!rst_n) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_wr        = 1'b0;
      pc_wr        = 1'b0;
      pc_src       = 2'b00;
      reg_wr       = 1'b0;
      reg_dst      = 2'b00;
      mem_to_reg   = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      alu_ctrl     = ALU_ADD;
      retire       = 1'b0;
      fault        = 1'b0;
      fault_code   = 2'b00;
      state        = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pending_q <= 1'b0;
      to_q      <= '0;
      fcode_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      to_q      <= to_d;
      fcode_q   <= fcode_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle expected control words from a vector
// table plus hand-built sequences for wait states, timeout, faults and reset.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_wr, pc_wr, reg_wr, mem_to_reg;
  logic        alu_src_a, retire, fault;
  logic [1:0]  pc_src, reg_dst, alu_src_b, fault_code;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(16), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .state(state), .retire(retire), .fault(fault), .fault_code(fault_code)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       retire;
    logic       fault;
    logic [1:0] fault_code;
  } outs_t;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic        r;
    logic        rdy;
    logic        z;
    outs_t       exp;
  } vec_t;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_SLT  = 32'h0022182A;
  localparam logic [31:0] I_ADDI = 32'h20220005;
  localparam logic [31:0] I_LW   = 32'h8C850008;
  localparam logic [31:0] I_SW   = 32'hAC850008;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BNE  = 32'h14220003;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_ILL  = 32'hF0000000;
  localparam logic [31:0] I_SUB  = 32'h00221822;

  int    n_tests = 0;
  int    n_fail  = 0;
  outs_t sb[$];
  string sb_nm[$];
  vec_t  tbl[$];

  function automatic outs_t e_zero();
    outs_t e = '0;
    return e;
  endfunction
  function automatic outs_t e_fetch(input logic req, input logic rdy);
    outs_t e = '0;
    e.state = 4'd0; e.mem_req = req; e.ir_wr = req & rdy; e.pc_wr = req & rdy;
    e.alu_src_b = 2'b01;
    return e;
  endfunction
  function automatic outs_t e_dec();
    outs_t e = '0;
    e.state = 4'd1; e.alu_src_b = 2'b11;
    return e;
  endfunction
  function automatic outs_t e_exr(input logic [2:0] c);
    outs_t e = '0;
    e.state = 4'd2; e.alu_src_a = 1'b1; e.alu_ctrl = c;
    return e;
  endfunction
  function automatic outs_t e_wbr(input logic [2:0] c);
    outs_t e = '0;
    e.state = 4'd3; e.reg_wr = 1'b1; e.reg_dst = 2'b01; e.retire = 1'b1;
    e.alu_src_a = 1'b1; e.alu_ctrl = c;
    return e;
  endfunction
  function automatic outs_t e_exi();
    outs_t e = '0;
    e.state = 4'd4; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    return e;
  endfunction
  function automatic outs_t e_wbi();
    outs_t e = '0;
    e.state = 4'd5; e.reg_wr = 1'b1; e.retire = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_ma();
    outs_t e = '0;
    e.state = 4'd6; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    return e;
  endfunction
  function automatic outs_t e_mrd();
    outs_t e = '0;
    e.state = 4'd7; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_wbm();
    outs_t e = '0;
    e.state = 4'd8; e.reg_wr = 1'b1; e.mem_to_reg = 1'b1; e.retire = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_mwr(input logic rdy);
    outs_t e = '0;
    e.state = 4'd9; e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_sel = 1'b1;
    e.retire = rdy;
    return e;
  endfunction
  function automatic outs_t e_br(input logic pcw);
    outs_t e = '0;
    e.state = 4'd10; e.alu_src_a = 1'b1; e.alu_ctrl = 3'd1; e.pc_src = 2'b01;
    e.pc_wr = pcw; e.retire = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_jr();
    outs_t e = '0;
    e.state = 4'd11; e.pc_wr = 1'b1; e.pc_src = 2'b11; e.retire = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_jal();
    outs_t e = '0;
    e.state = 4'd12; e.reg_wr = 1'b1; e.reg_dst = 2'b10; e.pc_wr = 1'b1;
    e.pc_src = 2'b10; e.retire = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_fault(input logic [1:0] code);
    outs_t e = '0;
    e.state = 4'd13; e.fault = 1'b1; e.fault_code = code;
    return e;
  endfunction

  task automatic chk();
    outs_t e, a;
    string nm;
    e  = sb.pop_front();
    nm = sb_nm.pop_front();
    a  = {state, mem_req, mem_we, mem_addr_sel, ir_wr, pc_wr, pc_src, reg_wr, reg_dst,
          mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, retire, fault, fault_code};
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got state=%0d word=%h, expected state=%0d word=%h",
               nm, a.state, a, e.state, e);
    end
  endtask

  task automatic expect_now(input string nm, input outs_t e);
    sb.push_back(e);
    sb_nm.push_back(nm);
    #1;
    chk();
  endtask

  task automatic cyc(input string nm, input logic [31:0] ins, input logic r,
                     input logic rdy, input logic z, input outs_t e);
    @(negedge clk);
    instr = ins; run = r; mem_ready = rdy; zero = z;
    expect_now(nm, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1;
    expect_now("reset async", e_zero());
    run = 1'b0;
    @(negedge clk);
    expect_now("reset held", e_zero());
    rst_n = 1'b1;
  endtask

  task automatic addv(input string nm, input logic [31:0] ins, input logic r,
                      input logic rdy, input logic z, input outs_t e);
    vec_t v;
    v.nm = nm; v.ins = ins; v.r = r; v.rdy = rdy; v.z = z; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    addv("add F", I_ADD, 1, 1, 0, e_fetch(1, 1));
    addv("add D", I_ADD, 1, 1, 0, e_dec());
    addv("add EX", I_ADD, 1, 1, 0, e_exr(3'd0));
    addv("add WB", I_ADD, 1, 1, 0, e_wbr(3'd0));
    addv("slt F", I_SLT, 1, 1, 0, e_fetch(1, 1));
    addv("slt D", I_SLT, 1, 1, 0, e_dec());
    addv("slt EX", I_SLT, 1, 1, 0, e_exr(3'd3));
    addv("slt WB", I_SLT, 1, 1, 0, e_wbr(3'd3));
    addv("addi F", I_ADDI, 1, 1, 0, e_fetch(1, 1));
    addv("addi D", I_ADDI, 1, 1, 0, e_dec());
    addv("addi EX", I_ADDI, 1, 1, 0, e_exi());
    addv("addi WB", I_ADDI, 1, 1, 0, e_wbi());
    addv("sw F", I_SW, 1, 1, 0, e_fetch(1, 1));
    addv("sw D", I_SW, 1, 1, 0, e_dec());
    addv("sw MA", I_SW, 1, 1, 0, e_ma());
    addv("sw MW", I_SW, 1, 1, 0, e_mwr(1));
    addv("beq z1 F", I_BEQ, 1, 1, 1, e_fetch(1, 1));
    addv("beq z1 D", I_BEQ, 1, 1, 1, e_dec());
    addv("beq z1 BR", I_BEQ, 1, 1, 1, e_br(1));
    addv("beq z0 F", I_BEQ, 1, 1, 0, e_fetch(1, 1));
    addv("beq z0 D", I_BEQ, 1, 1, 0, e_dec());
    addv("beq z0 BR", I_BEQ, 1, 1, 0, e_br(0));
    addv("bne z1 F", I_BNE, 1, 1, 1, e_fetch(1, 1));
    addv("bne z1 D", I_BNE, 1, 1, 1, e_dec());
    addv("bne z1 BR", I_BNE, 1, 1, 1, e_br(0));
    addv("bne z0 F", I_BNE, 1, 1, 0, e_fetch(1, 1));
    addv("bne z0 D", I_BNE, 1, 1, 0, e_dec());
    addv("bne z0 BR", I_BNE, 1, 1, 0, e_br(1));
    addv("jal F", I_JAL, 1, 1, 0, e_fetch(1, 1));
    addv("jal D", I_JAL, 1, 1, 0, e_dec());
    addv("jal X", I_JAL, 1, 1, 0, e_jal());
    addv("jr F", I_JR, 1, 1, 0, e_fetch(1, 1));
    addv("jr D", I_JR, 1, 1, 0, e_dec());
    addv("jr X", I_JR, 1, 1, 0, e_jr());
    addv("idle F1", I_ADD, 0, 1, 0, e_fetch(0, 1));
    addv("idle F2", I_ADD, 0, 1, 0, e_fetch(0, 1));

    do_reset();
    foreach (tbl[i]) cyc(tbl[i].nm, tbl[i].ins, tbl[i].r, tbl[i].rdy, tbl[i].z, tbl[i].exp);

    // lw with three memory wait states in MEM_RD
    do_reset();
    cyc("lw F", I_LW, 1, 1, 0, e_fetch(1, 1));
    cyc("lw D", I_LW, 1, 0, 0, e_dec());
    cyc("lw MA", I_LW, 1, 0, 0, e_ma());
    for (int i = 0; i < 3; i++) cyc("lw MR wait", I_LW, 1, 0, 0, e_mrd());
    cyc("lw MR done", I_LW, 1, 1, 0, e_mrd());
    cyc("lw WB", I_LW, 1, 0, 0, e_wbm());
    cyc("lw after", I_LW, 0, 0, 0, e_fetch(0, 0));

    // request held by the pending flag after run drops
    do_reset();
    cyc("pend req", I_ADDI, 1, 0, 0, e_fetch(1, 0));
    cyc("pend hold", I_ADDI, 0, 0, 0, e_fetch(1, 0));
    cyc("pend done", I_ADDI, 0, 1, 0, e_fetch(1, 1));
    cyc("pend D", I_ADDI, 0, 1, 0, e_dec());
    cyc("pend EX", I_ADDI, 0, 1, 0, e_exi());
    cyc("pend WB", I_ADDI, 0, 1, 0, e_wbi());
    cyc("pend cleared", I_ADDI, 0, 1, 0, e_fetch(0, 1));

    // fetch timeout: 16 stalled cycles then FAULT code 10
    do_reset();
    for (int i = 1; i <= 16; i++) cyc("to stall", I_ADD, 1, 0, 0, e_fetch(1, 0));
    cyc("to fault", I_ADD, 1, 0, 0, e_fault(2'b10));
    cyc("to run0", I_ADD, 0, 1, 0, e_fault(2'b10));
    cyc("to run1", I_ADD, 1, 1, 0, e_fault(2'b10));

    // ready on the 16th cycle wins over the timeout
    do_reset();
    for (int i = 1; i <= 15; i++) cyc("rdy16 stall", I_ADD, 1, 0, 0, e_fetch(1, 0));
    cyc("rdy16 done", I_ADD, 1, 1, 0, e_fetch(1, 1));
    cyc("rdy16 D", I_ADD, 0, 1, 0, e_dec());
    cyc("rdy16 EX", I_ADD, 0, 1, 0, e_exr(3'd0));
    cyc("rdy16 WB", I_ADD, 0, 1, 0, e_wbr(3'd0));
    cyc("rdy16 idle", I_ADD, 0, 1, 0, e_fetch(0, 1));

    // illegal opcode: terminal until reset
    do_reset();
    cyc("ill F", I_ILL, 1, 1, 0, e_fetch(1, 1));
    cyc("ill D", I_ILL, 1, 1, 0, e_dec());
    cyc("ill fault", I_ILL, 0, 1, 0, e_fault(2'b01));
    cyc("ill run1", I_ADD, 1, 1, 0, e_fault(2'b01));
    cyc("ill run0", I_ADD, 0, 1, 0, e_fault(2'b01));
    cyc("ill run1b", I_ADD, 1, 1, 0, e_fault(2'b01));

    // illegal R-type funct
    do_reset();
    cyc("ilf F", I_SUB, 1, 1, 0, e_fetch(1, 1));
    cyc("ilf D", I_SUB, 1, 1, 0, e_dec());
    cyc("ilf fault", I_SUB, 1, 1, 0, e_fault(2'b01));

    // reset asserted mid-MEM_WR drops the request without a clock edge
    do_reset();
    cyc("wr F", I_SW, 1, 1, 0, e_fetch(1, 1));
    cyc("wr D", I_SW, 1, 0, 0, e_dec());
    cyc("wr MA", I_SW, 1, 0, 0, e_ma());
    cyc("wr MW wait", I_SW, 1, 0, 0, e_mwr(0));
    #1;
    rst_n = 1'b0;
    expect_now("wr async reset", e_zero());
    @(negedge clk);
    run = 1'b0;
    expect_now("wr reset held", e_zero());
    rst_n = 1'b1;
    cyc("wr after reset", I_SW, 0, 1, 0, e_fetch(0, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
